color_index_encoder: RTL and testbench
======================================

Name: color_index_encoder

Overview:
- Inverse of the palette colour converter: accepts a 24-bit RGB pixel stream and encodes each pixel back to its 4-bit palette index (which_color).
- Used on the read-back / capture path, e.g. frame-buffer readout and sprite-sheet import into index-based memory.
- Two-stage valid/ready pipeline; counts pixels that match no palette entry.

Parameters:
BACKGROUND_COLOR  24'h000000  RGB for index 0
PLAYER_COLOR  24'h34CA7F  RGB for index 1
LASER_COLOR  24'hE91E63  RGB for index 2
ALIEN_COLOR  24'hFFFFFF  RGB for index 3
TITLE_TEXT_COLOR  24'hFFB11E  RGB for index 4
UNKNOWN_INDEX  4'd15  index emitted for RGB matching no entry
COUNT_W  16  width of miss counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
r  input  8  red component of input pixel
g  input  8  green component
b  input  8  blue component
in_valid  input  1  input pixel valid
in_ready  output  1  encoder can accept pixel this cycle
which_color  output  4  encoded palette index
miss  output  1  qualifies which_color: pixel matched no palette entry
out_valid  output  1  which_color/miss valid
out_ready  input  1  downstream accepts output this cycle
clear_count  input  1  synchronous clear of miss_count
miss_count  output  COUNT_W  saturating count of accepted miss outputs

Behaviour:
- Reset (async, active-high): all stage valid flags 0, out_valid=0, which_color=0, miss=0, miss_count=0. Pixels held in flight are discarded; no partial output after reset release.
- Input handshake: pixel is accepted when in_valid && in_ready on a rising edge. Output handshake: output is consumed when out_valid && out_ready.
- Stage 1 (S1): registers {r,g,b} and five equality compares against the palette parameters.
- Stage 2 (S2): priority-encodes the compare vector into which_color and miss. Registers feed the outputs directly.
- Priority: lowest index wins if parameters collide (e.g. ALIEN_COLOR==BACKGROUND_COLOR gives 0).
- No match: which_color=UNKNOWN_INDEX, miss=1. Any match: miss=0.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; no combinational path from in_valid to in_ready)
- Latency: 2 cycles from input acceptance to out_valid when out_ready is held 1. Throughput 1 pixel/cycle.
- Backpressure: while out_ready=0 with both stages full, in_ready=0, and S1/S2 contents hold stable. which_color and miss must not change while out_valid=1 and out_ready=0.
- Bubbles: if S1 is empty and S2 is consumed, out_valid drops to 0 next cycle.
- Ordering: strict FIFO order; no drops or duplicates.
- miss_count: increments by 1 on each output handshake with miss=1. Saturates at all-ones (no wrap).
- clear_count: sets miss_count to 0 next edge. Clear concurrent with a miss handshake gives 0 (clear wins).
- Outputs are fully registered except in_ready.

Test Plan:
- Reset mid-stream: feed 3 pixels, assert reset after cycle 2 → out_valid=0 immediately, miss_count=0; after release, no stale pixel is emitted.
- Palette sweep, out_ready=1: input 000000, 34CA7F, E91E63, FFFFFF, FFB11E on consecutive cycles → which_color 0,1,2,3,4 on consecutive cycles starting 2 cycles after first accept, miss=0, miss_count=0.
- Unknown colour: input 123456 then 34CA7E → which_color 15,15 with miss=1; miss_count=2 after both handshakes. Then pulse clear_count → 0.
- Backpressure: stream 6 pixels, hold out_ready=0 for cycles 3-7 → in_ready=0 once both stages are full; which_color stable while stalled; all 6 indices emitted in order after release, none lost or duplicated.
- Collision priority: instantiate with ALIEN_COLOR=24'h000000, input 000000 → which_color=0.
- Saturation and clear race: COUNT_W=2, send 5 unknown pixels → miss_count sticks at 3. Clear asserted on the same cycle as a miss handshake → miss_count=0.

Source files
------------

// File: rtl/color_index_encoder.sv
// Encodes a 24-bit RGB pixel stream back to 4-bit palette indices through a two-stage
// valid/ready pipeline, and keeps a saturating count of pixels that match no palette entry.
module color_index_encoder #(
    parameter logic [23:0] BACKGROUND_COLOR = 24'h000000,
    parameter logic [23:0] PLAYER_COLOR     = 24'h34CA7F,
    parameter logic [23:0] LASER_COLOR      = 24'hE91E63,
    parameter logic [23:0] ALIEN_COLOR      = 24'hFFFFFF,
    parameter logic [23:0] TITLE_TEXT_COLOR = 24'hFFB11E,
    parameter logic [3:0]  UNKNOWN_INDEX    = 4'd15,
    parameter int          COUNT_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [3:0]         which_color,
    output logic               miss,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clear_count,
    output logic [COUNT_W-1:0] miss_count
);

    logic               s1_valid_q, s1_valid_d;
    logic [4:0]         s1_match_q, s1_match_d;
    logic               s2_valid_q, s2_valid_d;
    logic [3:0]         which_color_q, which_color_d;
    logic               miss_q, miss_d;
    logic [COUNT_W-1:0] miss_count_q, miss_count_d;

    logic [23:0] pixel_rgb;
    logic [4:0]  match_in;
    logic        s1_adv;
    logic        s2_adv;

    always_comb begin
        pixel_rgb   = {r, g, b};
        match_in[0] = (pixel_rgb == BACKGROUND_COLOR);
        match_in[1] = (pixel_rgb == PLAYER_COLOR);
        match_in[2] = (pixel_rgb == LASER_COLOR);
        match_in[3] = (pixel_rgb == ALIEN_COLOR);
        match_in[4] = (pixel_rgb == TITLE_TEXT_COLOR);

        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;

        s1_valid_d = s1_valid_q;
        s1_match_d = s1_match_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_match_d = match_in;
            end
        end

        // Scanning from the top down lets the lowest matching index overwrite the rest.
        s2_valid_d    = s2_valid_q;
        which_color_d = which_color_q;
        miss_d        = miss_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                which_color_d = UNKNOWN_INDEX;
                miss_d        = 1'b1;
                for (int i = 4; i >= 0; i--) begin
                    if (s1_match_q[i]) begin
                        which_color_d = 4'(i);
                        miss_d        = 1'b0;
                    end
                end
            end
        end

        miss_count_d = miss_count_q;
        if (clear_count) begin
            miss_count_d = '0;
        end else if (s2_valid_q && out_ready && miss_q && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_match_q    <= '0;
            s2_valid_q    <= 1'b0;
            which_color_q <= '0;
            miss_q        <= 1'b0;
            miss_count_q  <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_match_q    <= s1_match_d;
            s2_valid_q    <= s2_valid_d;
            which_color_q <= which_color_d;
            miss_q        <= miss_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign which_color = which_color_q;
    assign miss        = miss_q;
    assign out_valid   = s2_valid_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_color_index_encoder.sv
// Directed bench for color_index_encoder: default palette, a colliding palette
// (ALIEN_COLOR = background) and a 2-bit miss counter, all driven from one input stream.
module tb_color_index_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] rgb = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clear_count = 1'b0;

    logic        in_ready, out_valid, miss;
    logic [3:0]  which_color;
    logic [15:0] miss_count;

    logic        col_in_ready, col_out_valid, col_miss;
    logic [3:0]  col_which_color;
    logic [15:0] col_miss_count;

    logic        sat_in_ready, sat_out_valid, sat_miss;
    logic [3:0]  sat_which_color;
    logic [1:0]  sat_miss_count;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] pal [5] = '{24'h000000, 24'h34CA7F, 24'hE91E63, 24'hFFFFFF, 24'hFFB11E};
    logic [3:0]  col_exp [5] = '{4'd0, 4'd1, 4'd2, 4'd15, 4'd4};
    logic [23:0] bp_pix [6] = '{24'hE91E63, 24'h123456, 24'hFFB11E, 24'h000000, 24'h34CA7F, 24'hFFFFFF};
    logic [3:0]  bp_exp [6] = '{4'd2, 4'd15, 4'd4, 4'd0, 4'd1, 4'd3};

    always #5 clock = ~clock;

    color_index_encoder dut (
        .clock(clock), .reset(reset),
        .r(rgb[23:16]), .g(rgb[15:8]), .b(rgb[7:0]),
        .in_valid(in_valid), .in_ready(in_ready),
        .which_color(which_color), .miss(miss), .out_valid(out_valid),
        .out_ready(out_ready), .clear_count(clear_count), .miss_count(miss_count)
    );

    color_index_encoder #(.ALIEN_COLOR(24'h000000)) dut_col (
        .clock(clock), .reset(reset),
        .r(rgb[23:16]), .g(rgb[15:8]), .b(rgb[7:0]),
        .in_valid(in_valid), .in_ready(col_in_ready),
        .which_color(col_which_color), .miss(col_miss), .out_valid(col_out_valid),
        .out_ready(out_ready), .clear_count(clear_count), .miss_count(col_miss_count)
    );

    color_index_encoder #(.COUNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .r(rgb[23:16]), .g(rgb[15:8]), .b(rgb[7:0]),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .which_color(sat_which_color), .miss(sat_miss), .out_valid(sat_out_valid),
        .out_ready(out_ready), .clear_count(clear_count), .miss_count(sat_miss_count)
    );

    task automatic apply_stimulus(input logic [23:0] pix, input logic v, input logic ordy,
                                  input logic clr);
        rgb         = pix;
        in_valid    = v;
        out_ready   = ordy;
        clear_count = clr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int  sent;
        int  recv;
        logic accepted;
        logic prev_stall;
        logic [3:0] prev_wc;

        // Power-on reset
        tick();
        tick();
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_which_color", which_color, 0);
        check_output("rst_miss", miss, 0);
        check_output("rst_miss_count", miss_count, 0);
        reset = 1'b0;
        #1;
        check_output("rst_in_ready", in_ready, 1);

        // Palette sweep, also watching the colliding-palette instance
        for (int i = 0; i < 7; i++) begin
            if (i < 5) apply_stimulus(pal[i], 1'b1, 1'b1, 1'b0);
            else       apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
            tick();
            if (i >= 1 && i <= 5) begin
                check_output("sweep_valid", out_valid, 1);
                check_output("sweep_idx", which_color, 32'(i - 1));
                check_output("sweep_miss", miss, 0);
                check_output("col_idx", col_which_color, col_exp[i-1]);
                check_output("col_miss", col_miss, (col_exp[i-1] == 4'd15) ? 1 : 0);
            end
        end
        check_output("sweep_drain", out_valid, 0);
        check_output("sweep_count", miss_count, 0);

        // Unknown colours, then clear
        apply_stimulus(24'h123456, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(24'h34CA7E, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("unk0_idx", which_color, 15);
        check_output("unk0_miss", miss, 1);
        check_output("unk0_count", miss_count, 0);
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("unk1_idx", which_color, 15);
        check_output("unk1_miss", miss, 1);
        check_output("unk1_count", miss_count, 1);
        tick();
        check_output("unk_drain", out_valid, 0);
        check_output("unk_count", miss_count, 2);
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("unk_clear", miss_count, 0);
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure: out_ready low during cycles 3..7
        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        prev_wc = '0;
        for (int cyc = 1; cyc <= 30 && recv < 6; cyc++) begin
            apply_stimulus((sent < 6) ? bp_pix[sent] : 24'h0, (sent < 6),
                           !(cyc >= 3 && cyc <= 7), 1'b0);
            #1;
            if (cyc >= 3 && cyc <= 7) check_output("bp_in_ready", in_ready, 0);
            if (prev_stall) check_output("bp_stable", which_color, prev_wc);
            if (out_valid && out_ready) begin
                check_output("bp_order", which_color, bp_exp[recv]);
                check_output("bp_miss", miss, (bp_exp[recv] == 4'd15) ? 1 : 0);
                recv++;
            end
            accepted   = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_wc    = which_color;
            tick();
            if (accepted) sent++;
        end
        check_output("bp_received", recv, 6);
        check_output("bp_no_dup", out_valid, 0);
        check_output("bp_count", miss_count, 1);

        // Saturation of the 2-bit counter
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(24'h123456, 1'b1, 1'b1, 1'b0);
            tick();
        end
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check_output("sat_count", sat_miss_count, 3);
        check_output("sat_main_count", miss_count, 5);
        check_output("sat_drain", out_valid, 0);

        // Clear on the same edge as a miss handshake
        apply_stimulus(24'hABCDEF, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("race_valid", out_valid, 1);
        check_output("race_miss", miss, 1);
        check_output("race_pre_count", sat_miss_count, 3);
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("race_sat_count", sat_miss_count, 0);
        check_output("race_main_count", miss_count, 0);
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream
        apply_stimulus(24'h123456, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(24'hABCDEF, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(24'h34CA7E, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("mid_pre_valid", out_valid, 1);
        check_output("mid_pre_count", miss_count, 1);
        reset = 1'b1;
        #1;
        check_output("mid_out_valid", out_valid, 0);
        check_output("mid_which_color", which_color, 0);
        check_output("mid_miss", miss, 0);
        check_output("mid_count", miss_count, 0);
        tick();
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("mid_no_stale", out_valid, 0);
        end
        apply_stimulus(24'h34CA7F, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(24'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("mid_fresh_valid", out_valid, 1);
        check_output("mid_fresh_idx", which_color, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
